// File: rtl/axis_pixels_header_pkg.sv
// Shared constants and header field layout for the pixel-stream header path.
// The same hdr_t layout is used by the row reshaper and by software header packing.
package axis_pixels_header_pkg;

  localparam int AXI_WIDTH_DEF    = 128;
  localparam int WORD_WIDTH_DEF   = 8;
  localparam int HEADER_WIDTH_DEF = 64;

  localparam int KEEP_W = AXI_WIDTH_DEF / WORD_WIDTH_DEF;
  localparam int USER_W = HEADER_WIDTH_DEF + 1;

  localparam int CI_MAX = 1024;
  localparam int XW_MAX = 512;
  localparam int XH_MAX = 512;
  localparam int ROWS   = 8;
  localparam int KH_MAX = 11;

  localparam int CI_W  = $clog2(CI_MAX + 1);
  localparam int L_W   = $clog2(XH_MAX / ROWS + 1);
  localparam int W_W   = $clog2(XW_MAX + 1);
  localparam int KH2_W = $clog2(KH_MAX / 2 + 1);

  typedef struct packed {
    logic [CI_W-1:0]  ref_ci_p;
    logic [CI_W-1:0]  ref_ci_p0;
    logic [L_W-1:0]   ref_l;
    logic [W_W-1:0]   ref_w;
    logic [KH2_W-1:0] ref_kh2;
  } hdr_t;

  localparam int HDR_T_W = $bits(hdr_t);

endpackage

// File: rtl/axis_skid_reg.sv
// Generic two-entry AXI-Stream register slice: registered valid/data on the
// master side and a registered ready on the slave side.
module axis_skid_reg #(
  parameter int WIDTH = 8
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  logic             main_valid_r;
  logic             skid_valid_r;
  logic             ready_r;
  logic [WIDTH-1:0] main_data_r;
  logic [WIDTH-1:0] skid_data_r;

  logic             push_s;
  logic             main_open_s;
  logic             main_valid_nxt_s;
  logic             skid_valid_nxt_s;
  logic [WIDTH-1:0] main_data_nxt_s;
  logic [WIDTH-1:0] skid_data_nxt_s;

  // Next-state for main/skid entries; the skid only fills while main is stalled.
  always_comb begin
    push_s           = s_valid && ready_r;
    main_open_s      = !main_valid_r || m_ready;
    main_valid_nxt_s = main_valid_r;
    main_data_nxt_s  = main_data_r;
    skid_valid_nxt_s = skid_valid_r;
    skid_data_nxt_s  = skid_data_r;
    if (main_open_s) begin
      if (skid_valid_r) begin
        main_valid_nxt_s = 1'b1;
        main_data_nxt_s  = skid_data_r;
        skid_valid_nxt_s = 1'b0;
      end else if (push_s) begin
        main_valid_nxt_s = 1'b1;
        main_data_nxt_s  = s_data;
      end else begin
        main_valid_nxt_s = 1'b0;
      end
    end else if (push_s) begin
      skid_valid_nxt_s = 1'b1;
      skid_data_nxt_s  = s_data;
    end else begin
      skid_valid_nxt_s = skid_valid_r;
    end
  end

  // Entry registers; ready is registered from the next skid occupancy.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      ready_r      <= 1'b0;
      main_data_r  <= '0;
      skid_data_r  <= '0;
    end else begin
      main_valid_r <= main_valid_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      ready_r      <= !skid_valid_nxt_s;
      main_data_r  <= main_data_nxt_s;
      skid_data_r  <= skid_data_nxt_s;
    end
  end

  assign s_ready = ready_r;
  assign m_valid = main_valid_r;
  assign m_data  = main_data_r;

endmodule

// File: rtl/axis_pixels_header.sv
// Strips the header beat of each packet and replays it on m_user with every
// pixel beat of that packet, through a registered skid output stage.
module axis_pixels_header
  import axis_pixels_header_pkg::*;
#(
  parameter int AXI_WIDTH    = AXI_WIDTH_DEF,
  parameter int WORD_WIDTH   = WORD_WIDTH_DEF,
  parameter int HEADER_WIDTH = HEADER_WIDTH_DEF
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  output logic                            s_ready,
  input  logic                            s_valid,
  input  logic                            s_last,
  input  logic [AXI_WIDTH-1:0]            s_data,
  input  logic [AXI_WIDTH/WORD_WIDTH-1:0] s_keep,
  input  logic                            m_ready,
  output logic                            m_valid,
  output logic                            m_last,
  output logic [AXI_WIDTH-1:0]            m_data,
  output logic [AXI_WIDTH/WORD_WIDTH-1:0] m_keep,
  output logic [HEADER_WIDTH:0]           m_user,
  output logic                            hdr_err
);

  localparam int KW = AXI_WIDTH / WORD_WIDTH;
  localparam int UW = HEADER_WIDTH + 1;
  localparam int PW = UW + 1 + KW + AXI_WIDTH;

  localparam logic [0:0] ST_HDR  = 1'b0;
  localparam logic [0:0] ST_DATA = 1'b1;

  logic [0:0]              state_r;
  logic [HEADER_WIDTH-1:0] hdr_r;
  logic                    first_pend_r;
  logic                    hdr_err_r;
  logic                    hdr_ready_r;

  logic          s_ready_s;
  logic          xfer_s;
  logic          sk_s_valid_s;
  logic          sk_s_ready_s;
  logic          sk_m_valid_s;
  logic [PW-1:0] sk_s_data_s;
  logic [PW-1:0] sk_m_data_s;

  // Header beats never enter the output stage, so HDR accepts regardless of it.
  always_comb begin
    s_ready_s    = 1'b0;
    sk_s_valid_s = 1'b0;
    case (state_r)
      ST_HDR: begin
        s_ready_s = hdr_ready_r;
      end
      ST_DATA: begin
        s_ready_s    = sk_s_ready_s;
        sk_s_valid_s = s_valid;
      end
      default: begin
        s_ready_s    = 1'b0;
        sk_s_valid_s = 1'b0;
      end
    endcase
  end

  assign xfer_s      = s_valid && s_ready_s;
  assign sk_s_data_s = {hdr_r, first_pend_r, s_last, s_keep, s_data};

  // Packet framing: capture header, flag header-only packets, track first pixel.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r      <= ST_HDR;
      hdr_r        <= '0;
      first_pend_r <= 1'b0;
      hdr_err_r    <= 1'b0;
      hdr_ready_r  <= 1'b0;
    end else begin
      hdr_ready_r <= 1'b1;
      case (state_r)
        ST_HDR: begin
          if (xfer_s) begin
            if (s_last) begin
              hdr_err_r <= 1'b1;
            end else begin
              hdr_r        <= s_data[HEADER_WIDTH-1:0];
              first_pend_r <= 1'b1;
              state_r      <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (xfer_s) begin
            first_pend_r <= 1'b0;
            if (s_last) begin
              state_r <= ST_HDR;
            end
          end
        end
        default: begin
          state_r <= ST_HDR;
        end
      endcase
    end
  end

  axis_skid_reg #(
    .WIDTH (PW)
  ) u_out (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_valid (sk_s_valid_s),
    .s_ready (sk_s_ready_s),
    .s_data  (sk_s_data_s),
    .m_valid (sk_m_valid_s),
    .m_ready (m_ready),
    .m_data  (sk_m_data_s)
  );

  assign s_ready = s_ready_s;
  assign m_valid = sk_m_valid_s;
  assign m_data  = sk_m_data_s[AXI_WIDTH-1:0];
  assign m_keep  = sk_m_data_s[AXI_WIDTH +: KW];
  assign m_last  = sk_m_data_s[AXI_WIDTH + KW];
  assign m_user  = sk_m_data_s[AXI_WIDTH + KW + 1 +: UW];
  assign hdr_err = hdr_err_r;

endmodule

// File: tb/tb_axis_pixels_header.sv
// Self-checking bench for axis_pixels_header: directed scenarios plus random
// packets scored against a packet-level queue model.
`timescale 1ns/1ps
module tb_axis_pixels_header;
  import axis_pixels_header_pkg::*;

  localparam int AW = 128;
  localparam int WW = 8;
  localparam int HW = 64;
  localparam int KW = KEEP_W;
  localparam int UW = USER_W;

  typedef struct packed {
    logic [AW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic [UW-1:0] u;
  } beat_t;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          s_ready;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic [AW-1:0] s_data = '0;
  logic [KW-1:0] s_keep = '0;
  logic          m_ready = 1'b0;
  logic          m_valid;
  logic          m_last;
  logic [AW-1:0] m_data;
  logic [KW-1:0] m_keep;
  logic [UW-1:0] m_user;
  logic          hdr_err;

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  beat_t exp_q[$];
  logic  mon_en = 1'b0;
  logic  mr_rand = 1'b0;
  logic  hold_v = 1'b0;
  beat_t hold_b;
  beat_t got_b;
  beat_t exp_b;

  axis_pixels_header #(
    .AXI_WIDTH    (AW),
    .WORD_WIDTH   (WW),
    .HEADER_WIDTH (HW)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_ready (s_ready),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_data  (s_data),
    .s_keep  (s_keep),
    .m_ready (m_ready),
    .m_valid (m_valid),
    .m_last  (m_last),
    .m_data  (m_data),
    .m_keep  (m_keep),
    .m_user  (m_user),
    .hdr_err (hdr_err)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  always begin
    @(posedge aclk);
    #1;
    if (mr_rand) m_ready = 1'($urandom_range(0, 1));
  end

  // Output scoreboard: every handshake pops the model queue; stalled beats must hold.
  always @(negedge aclk) begin
    if (mon_en) begin
      got_b = {m_data, m_keep, m_last, m_user};
      if (hold_v) begin
        checks++;
        if (m_valid !== 1'b1 || got_b !== hold_b) begin
          errors++;
          $display("FAIL stall_stable: got v=%0b %h, required v=1 %h", m_valid, got_b, hold_b);
        end
      end
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got data=%h user=%h, required no beat", m_data, m_user);
        end else begin
          exp_b = exp_q.pop_front();
          if (got_b !== exp_b) begin
            errors++;
            $display("FAIL out_beat: got %h, required %h", got_b, exp_b);
          end
        end
      end
      hold_v = (m_valid === 1'b1) && (m_ready !== 1'b1);
      hold_b = got_b;
    end else begin
      hold_v = 1'b0;
    end
  end

  function automatic logic [KW-1:0] rand_keep();
    logic [KW-1:0] k;
    case ($urandom_range(0, 3))
      0: k = '1;
      1: k = '0;
      2: k = KW'($urandom);
      default: k = {KW{1'b1}} >> $urandom_range(0, KW - 1);
    endcase
    return k;
  endfunction

  task automatic drive_beat(input logic [AW-1:0] d, input logic [KW-1:0] k, input logic l, input bit gaps);
    bit acc;
    int n;
    if (gaps) begin
      while ($urandom_range(0, 1) == 0) begin
        s_valid = 1'b0;
        @(posedge aclk); #1;
      end
    end
    s_valid = 1'b1; s_data = d; s_keep = k; s_last = l;
    n = 0;
    do begin
      @(negedge aclk);
      acc = (s_ready === 1'b1);
      n++;
      @(posedge aclk); #1;
    end while (!acc && n < 300);
    s_valid = 1'b0; s_last = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL s_ready_timeout: got no acceptance in %0d cycles, required acceptance", n);
    end
  endtask

  // Model: each pixel beat leaves unchanged with user = {its packet's header, first-beat flag}.
  task automatic send_pkt(input logic [HW-1:0] hdr, input int n, input bit gaps);
    logic [AW-1:0] dq[$];
    logic [KW-1:0] kq[$];
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = {$urandom, $urandom, $urandom, $urandom};
      b.k = rand_keep();
      b.l = (i == n - 1);
      b.u = {hdr, (i == 0)};
      dq.push_back(b.d);
      kq.push_back(b.k);
      exp_q.push_back(b);
    end
    drive_beat({$urandom, $urandom, hdr}, rand_keep(), 1'b0, gaps);
    for (int i = 0; i < n; i++) drive_beat(dq[i], kq[i], (i == n - 1), gaps);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || m_valid === 1'b1) && n < 3000) begin
      @(posedge aclk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d beats missing, required 0", tag, exp_q.size());
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checks++;
    if ({m_valid, m_last, m_data, m_keep, m_user, hdr_err, s_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b l=%0b d=%h k=%h u=%h e=%0b r=%0b, required all 0",
               m_valid, m_last, m_data, m_keep, m_user, hdr_err, s_ready);
    end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    @(negedge aclk);
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %0b, required 1", s_ready);
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_basic();
    logic [AW-1:0] d[3];
    logic [KW-1:0] k[3];
    logic [HW-1:0] hdr = 64'hAB;
    mon_en = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d[i] = {$urandom, $urandom, $urandom, $urandom};
      k[i] = rand_keep();
    end
    s_valid = 1'b1; s_data = {$urandom, $urandom, hdr}; s_keep = '1; s_last = 1'b0;
    @(negedge aclk);
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL basic_hdr_ready: got %0b, required 1", s_ready); end
    @(posedge aclk); #1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        s_data = d[i]; s_keep = k[i]; s_last = (i == 2);
      end else begin
        s_valid = 1'b0; s_last = 1'b0;
      end
      @(negedge aclk);
      checks++;
      if (i == 0) begin
        if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_hdr_fwd: got m_valid=%0b, required 0", m_valid); end
      end else if ({m_valid, m_data, m_keep, m_last, m_user} !== {1'b1, d[i-1], k[i-1], (i == 3), hdr, (i == 1)}) begin
        errors++;
        $display("FAIL basic_beat%0d: got v=%0b d=%h k=%h l=%0b u=%h, required v=1 d=%h k=%h l=%0b u=%h",
                 i - 1, m_valid, m_data, m_keep, m_last, m_user, d[i-1], k[i-1], (i == 3), {hdr, (i == 1)});
      end
      @(posedge aclk); #1;
    end
    @(negedge aclk);
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_idle: got m_valid=%0b, required 0", m_valid); end
    @(posedge aclk); #1;
  endtask

  task automatic test_stall();
    logic mr[6]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic rdy[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [AW-1:0] d[3];
    logic [HW-1:0] hdr = 64'hCD;
    beat_t b;
    int p = 0;
    mon_en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d[i] = {$urandom, $urandom, $urandom, $urandom};
      b.d = d[i]; b.k = '1; b.l = (i == 2); b.u = {hdr, (i == 0)};
      exp_q.push_back(b);
    end
    drive_beat({64'h0, hdr}, '0, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      m_ready = mr[c];
      s_valid = (p < 3);
      if (p < 3) begin s_data = d[p]; s_keep = '1; s_last = (p == 2); end
      @(negedge aclk);
      if (c < 5) begin
        checks++;
        if (s_ready !== rdy[c]) begin
          errors++;
          $display("FAIL stall_ready_c%0d: got %0b, required %0b", c, s_ready, rdy[c]);
        end
      end
      if (s_valid && s_ready === 1'b1) p++;
      @(posedge aclk); #1;
    end
    s_valid = 1'b0; s_last = 1'b0;
    checks++;
    if (p != 3) begin errors++; $display("FAIL stall_accepted: got %0d beats, required 3", p); end
    wait_drain("stall");
  endtask

  task automatic test_overlap();
    mon_en = 1'b1; m_ready = 1'b0;
    fork
      begin
        send_pkt(64'h11, 2, 1'b0);
        send_pkt(64'h22, 2, 1'b0);
      end
      begin
        repeat (4) @(posedge aclk);
        #1 m_ready = 1'b1;
      end
    join
    wait_drain("overlap");
  endtask

  task automatic test_back_to_back();
    int t0;
    mon_en = 1'b1; m_ready = 1'b1;
    t0 = cyc;
    send_pkt({$urandom, $urandom}, 16, 1'b0);
    send_pkt({$urandom, $urandom}, 16, 1'b0);
    checks++;
    if (cyc - t0 != 34) begin errors++; $display("FAIL b2b_in_rate: got %0d cycles, required 34", cyc - t0); end
    checks++;
    if (exp_q.size() != 1) begin errors++; $display("FAIL b2b_out_rate: got %0d pending, required 1", exp_q.size()); end
    wait_drain("b2b");
  endtask

  task automatic test_random();
    mon_en = 1'b1; mr_rand = 1'b1;
    for (int p = 0; p < 20; p++) send_pkt({$urandom, $urandom}, $urandom_range(1, 64), 1'b1);
    mr_rand = 1'b0; m_ready = 1'b1;
    wait_drain("random");
  endtask

  task automatic test_hdr_err();
    mon_en = 1'b1; m_ready = 1'b1;
    checks++;
    if (hdr_err !== 1'b0) begin errors++; $display("FAIL hdr_err_clear: got %0b, required 0", hdr_err); end
    drive_beat({$urandom, $urandom, 64'hEE}, '1, 1'b1, 1'b0);
    repeat (2) @(posedge aclk);
    #1;
    checks++;
    if (hdr_err !== 1'b1) begin errors++; $display("FAIL hdr_err_set: got %0b, required 1", hdr_err); end
    send_pkt(64'h33, 3, 1'b0);
    wait_drain("hdr_err");
    checks++;
    if (hdr_err !== 1'b1) begin errors++; $display("FAIL hdr_err_sticky: got %0b, required 1", hdr_err); end
  endtask

  task automatic test_reset_mid();
    mon_en = 1'b0; m_ready = 1'b0;
    drive_beat({$urandom, $urandom, 64'h55}, '1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) drive_beat({$urandom, $urandom, $urandom, $urandom}, '1, 1'b0, 1'b0);
    aresetn = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    checks++;
    if ({m_valid, hdr_err, s_ready} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid_state: got v=%0b e=%0b r=%0b, required 0 0 0", m_valid, hdr_err, s_ready);
    end
    @(posedge aclk); #1;
    mon_en = 1'b1; m_ready = 1'b1;
    send_pkt(64'h44, 2, 1'b0);
    wait_drain("rst_mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_overlap();
    test_back_to_back();
    test_random();
    test_hdr_err();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
